// File: rtl/mux_8_to_1_pkg.sv
// Shared constants for the registered 8-to-1 selector.
// Select width and named select indices for inputs a..h.
package mux_8_to_1_pkg;

   localparam int SEL_W = 3;

   localparam logic [SEL_W-1:0] SEL_A = 3'd0;
   localparam logic [SEL_W-1:0] SEL_B = 3'd1;
   localparam logic [SEL_W-1:0] SEL_C = 3'd2;
   localparam logic [SEL_W-1:0] SEL_D = 3'd3;
   localparam logic [SEL_W-1:0] SEL_E = 3'd4;
   localparam logic [SEL_W-1:0] SEL_F = 3'd5;
   localparam logic [SEL_W-1:0] SEL_G = 3'd6;
   localparam logic [SEL_W-1:0] SEL_H = 3'd7;

endpackage

// File: rtl/mux_8_to_1_mux4.sv
// Combinational 4-to-1 selector used for each half of the 8-to-1.
// Ports: i0..i3 data (WIDTH), sel 2-bit select, o selected data.
module mux_4_to_1
   import mux_8_to_1_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic [WIDTH-1:0] i0,
   input  logic [WIDTH-1:0] i1,
   input  logic [WIDTH-1:0] i2,
   input  logic [WIDTH-1:0] i3,
   input  logic [1:0]       sel,
   output logic [WIDTH-1:0] o
);

   localparam logic [1:0] S0 = SEL_A[1:0];
   localparam logic [1:0] S1 = SEL_B[1:0];
   localparam logic [1:0] S2 = SEL_C[1:0];
   localparam logic [1:0] S3 = SEL_D[1:0];

   // Unknown select resolves to zero rather than propagating X.
   always_comb begin
      o = '0;
      case (sel)
         S0:      o = i0;
         S1:      o = i1;
         S2:      o = i2;
         S3:      o = i3;
         default: o = '0;
      endcase
   end

endmodule

// File: rtl/mux_8_to_1.sv
// Registered 8-to-1 selector: two 4:1 halves, a 2:1 on s2, output flop.
// Ports: clk, rst (sync, active high), a..h data, s0..s2 select, y output.
module mux_8_to_1
   import mux_8_to_1_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   input  logic [WIDTH-1:0] e,
   input  logic [WIDTH-1:0] f,
   input  logic [WIDTH-1:0] g,
   input  logic [WIDTH-1:0] h,
   input  logic             s0,
   input  logic             s1,
   input  logic             s2,
   output logic [WIDTH-1:0] y
);

   logic [1:0]       sel_lo;
   logic [WIDTH-1:0] lo;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] nxt;

   assign sel_lo = {s1, s0};

   mux_4_to_1 #(.WIDTH(WIDTH)) u_lo (
      .i0  (a),
      .i1  (b),
      .i2  (c),
      .i3  (d),
      .sel (sel_lo),
      .o   (lo)
   );

   mux_4_to_1 #(.WIDTH(WIDTH)) u_hi (
      .i0  (e),
      .i1  (f),
      .i2  (g),
      .i3  (h),
      .sel (sel_lo),
      .o   (hi)
   );

   // Unknown s2 yields zero, matching the 4:1 default branches.
   always_comb begin
      nxt = '0;
      case (s2)
         1'b0:    nxt = lo;
         1'b1:    nxt = hi;
         default: nxt = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) y <= '0;
      else     y <= nxt;
   end

endmodule

// File: tb/tb_mux_8_to_1.sv
// Directed self-checking bench for mux_8_to_1 (WIDTH=8).
// Ports: drives clk, rst, a..h, s0..s2; checks y one cycle later.
module tb_mux_8_to_1;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] din [8];
   logic [2:0]   sel;
   logic [W-1:0] y;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mux_8_to_1 #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .a   (din[0]),
      .b   (din[1]),
      .c   (din[2]),
      .d   (din[3]),
      .e   (din[4]),
      .f   (din[5]),
      .g   (din[6]),
      .h   (din[7]),
      .s0  (sel[0]),
      .s1  (sel[1]),
      .s2  (sel[2]),
      .y   (y)
   );

   task automatic chk(input string tag,
                      input logic [W-1:0] got,
                      input logic [W-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Sweep data a..h = 0,0,1,0,1,0,1,1
   logic [W-1:0] sw_data [8];
   logic [2:0]   sw_sel  [8];
   logic [W-1:0] sw_exp  [8];

   initial begin
      sw_data = '{8'h00, 8'h00, 8'h01, 8'h00,
                  8'h01, 8'h00, 8'h01, 8'h01};
      sw_sel  = '{3'b000, 3'b010, 3'b001, 3'b011,
                  3'b100, 3'b110, 3'b101, 3'b111};
      sw_exp  = '{8'h00, 8'h01, 8'h00, 8'h00,
                  8'h01, 8'h01, 8'h00, 8'h01};

      // Reset with arbitrary inputs
      rst = 1'b1;
      sel = 3'b101;
      for (int i = 0; i < 8; i++) din[i] = 8'hA5 ^ 8'(i);
      step();
      chk("rst_c1", y, 8'h00);
      step();
      chk("rst_c2", y, 8'h00);

      // Release with sel=0, a=1
      rst = 1'b0;
      sel = 3'b000;
      din[0] = 8'h01;
      step();
      chk("rst_rel", y, 8'h01);

      // Full select sweep
      for (int i = 0; i < 8; i++) din[i] = sw_data[i];
      for (int i = 0; i < 8; i++) begin
         sel = sw_sel[i];
         step();
         chk($sformatf("sweep%0d", i), y, sw_exp[i]);
      end

      // Latency
      din[0] = 8'h00;
      din[7] = 8'h01;
      sel = 3'b000;
      step();
      chk("lat_n", y, 8'h00);
      sel = 3'b111;
      #2;
      chk("lat_hold", y, 8'h00);
      step();
      chk("lat_n1", y, 8'h01);

      // Reset mid-operation
      step();
      chk("mid_pre", y, 8'h01);
      rst = 1'b1;
      step();
      chk("mid_rst", y, 8'h00);
      rst = 1'b0;
      step();
      chk("mid_rel", y, 8'h01);

      // One-hot walk
      for (int i = 0; i < 8; i++) din[i] = 8'h01 << i;
      for (int k = 0; k < 8; k++) begin
         sel = 3'(k);
         step();
         chk($sformatf("walk%0d", k), y, 8'h01 << k);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
